// File: rtl/alu_io_pkg.sv
// Shared types and constants for the ALU operand front-end: FSM state
// encoding, flag bit positions and the flag packing helper.
package alu_io_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GOT_A = 3'd1,
      EXEC  = 3'd2,
      SHOW  = 3'd3
   } state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Packs the individual ALU flag lines into the {N, Z, C, V} display word.
   function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Two-flop synchronizer for the asynchronous push-button followed by a
// rising-edge detector producing one single-cycle press per button press.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   logic s1;
   logic s2;
   logic s3;

   // s1/s2 resynchronize btn; s3 remembers the previous synchronized level
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign press = s2 & ~s3;

endmodule

// File: rtl/operand_loader.sv
// Loads ALU operands A and B from switches on successive button presses and
// captures the ALU result and flags one cycle after B is loaded.
module operand_loader
   import alu_io_pkg::*;
#(
   parameter int M     = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [M-1:0]     sw,
   input  logic             btn,
   input  logic [M-1:0]     R_in,
   input  logic             C_in,
   input  logic             N_in,
   input  logic             V_in,
   input  logic             Z_in,
   output logic [M-1:0]     A,
   output logic [M-1:0]     B,
   output logic [M-1:0]     R_q,
   output logic [3:0]       flags_q,
   output logic             valid,
   output logic [CNT_W-1:0] op_count,
   output logic [2:0]       state_o
);

   logic   press;
   state_t state;

   edge_detect u_edge_detect (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn),
      .press (press)
   );

   // EXEC ignores press entirely, so a pulse landing there is dropped rather
   // than queued; A/B only move on press edges, keeping the ALU stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         A        <= '0;
         B        <= '0;
         R_q      <= '0;
         flags_q  <= '0;
         valid    <= 1'b0;
         op_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (press) begin
                  A     <= sw;
                  state <= GOT_A;
               end
            end
            GOT_A: begin
               if (press) begin
                  B     <= sw;
                  state <= EXEC;
               end
            end
            EXEC: begin
               R_q      <= R_in;
               flags_q  <= pack_flags(N_in, Z_in, C_in, V_in);
               valid    <= 1'b1;
               op_count <= op_count + 1'b1;
               state    <= SHOW;
            end
            SHOW: begin
               if (press) begin
                  A     <= sw;
                  valid <= 1'b0;
                  state <= GOT_A;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a small AND-based ALU model in the loop.
module tb_operand_loader;
   import alu_io_pkg::*;

   localparam int M     = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [M-1:0]     sw  = '0;
   logic             btn = 1'b0;
   logic [M-1:0]     R_in;
   logic             C_in, N_in, V_in, Z_in;
   logic [M-1:0]     A, B, R_q;
   logic [3:0]       flags_q;
   logic             valid;
   logic [CNT_W-1:0] op_count;
   logic [2:0]       state_o;

   int total = 0;
   int bad   = 0;

   operand_loader #(.M(M), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .sw(sw), .btn(btn),
      .R_in(R_in), .C_in(C_in), .N_in(N_in), .V_in(V_in), .Z_in(Z_in),
      .A(A), .B(B), .R_q(R_q), .flags_q(flags_q), .valid(valid),
      .op_count(op_count), .state_o(state_o)
   );

   // ALU model: R = A & B, Z = (R == 0), N = sign bit, C = V = 0
   assign R_in = A & B;
   assign Z_in = (R_in == '0);
   assign N_in = R_in[M-1];
   assign C_in = 1'b0;
   assign V_in = 1'b0;

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // btn rises; the press acts on the 3rd edge. Returns just after that edge.
   task automatic press_act(input logic [M-1:0] v);
      sw  = v;
      btn = 1'b1;
      repeat (3) tick();
      btn = 1'b0;
      sw  = ~v;
   endtask

   task automatic settle();
      repeat (3) tick();
   endtask

   initial begin
      // reset with btn held high and switches at all ones
      btn = 1'b1;
      sw  = 4'hF;
      rst = 1'b1;
      repeat (2) tick();
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_A", 32'(A), 32'd0);
      check("rst_B", 32'(B), 32'd0);
      check("rst_Rq", 32'(R_q), 32'd0);
      check("rst_flags", 32'(flags_q), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_count", 32'(op_count), 32'd0);
      rst = 1'b0;
      repeat (2) tick();
      check("rel_2nd_edge_state", 32'(state_o), 32'd0);
      tick();
      check("rel_3rd_edge_state", 32'(state_o), 32'd1);
      check("rel_3rd_edge_A", 32'(A), 32'hF);
      btn = 1'b0;
      settle();

      // basic op: 5 & 3 = 1
      do_reset();
      press_act(4'h5);
      check("basic_A", 32'(A), 32'h5);
      check("basic_state_a", 32'(state_o), 32'd1);
      settle();
      press_act(4'h3);
      check("basic_B", 32'(B), 32'h3);
      check("basic_state_exec", 32'(state_o), 32'd2);
      check("basic_valid_pre", 32'(valid), 32'd0);
      tick();
      check("basic_Rq", 32'(R_q), 32'h1);
      check("basic_flags", 32'(flags_q), 32'b0000);
      check("basic_valid", 32'(valid), 32'd1);
      check("basic_count", 32'(op_count), 32'd1);
      check("basic_state_show", 32'(state_o), 32'd3);
      settle();
      check("basic_hold_state", 32'(state_o), 32'd3);
      check("basic_hold_Rq", 32'(R_q), 32'h1);

      // zero flag: A & 5 with A = A gives 0
      press_act(4'hA);
      check("zero_A", 32'(A), 32'hA);
      check("zero_valid_clr", 32'(valid), 32'd0);
      settle();
      press_act(4'h5);
      tick();
      check("zero_Rq", 32'(R_q), 32'h0);
      check("zero_flagZ", 32'(flags_q[FLAG_Z]), 32'd1);
      check("zero_flags", 32'(flags_q), 32'b0100);
      check("zero_valid", 32'(valid), 32'd1);
      check("zero_count", 32'(op_count), 32'd2);
      settle();
      press_act(4'h6);
      check("show_A", 32'(A), 32'h6);
      check("show_valid", 32'(valid), 32'd0);
      check("show_state", 32'(state_o), 32'd1);
      check("show_B_kept", 32'(B), 32'h5);
      settle();

      // negative flag: 6 & 0xC = 4, then C & D... use A=0xC, B=0xA -> 8
      do_reset();
      press_act(4'hC);
      settle();
      press_act(4'hA);
      tick();
      check("neg_Rq", 32'(R_q), 32'h8);
      check("neg_flags", 32'(flags_q), 32'b1000);
      settle();

      // long hold: one transition only, switch changes mid-hold ignored
      do_reset();
      sw  = 4'h7;
      btn = 1'b1;
      repeat (5) tick();
      sw = 4'h8;
      repeat (45) tick();
      check("hold_state", 32'(state_o), 32'd1);
      check("hold_A", 32'(A), 32'h7);
      check("hold_B", 32'(B), 32'h0);
      btn = 1'b0;
      settle();
      check("hold_rel_state", 32'(state_o), 32'd1);
      press_act(4'h2);
      check("hold_B_load", 32'(B), 32'h2);
      check("hold_exec", 32'(state_o), 32'd2);

      // press forced during EXEC is dropped
      sw = 4'hC;
      force dut.press = 1'b1;
      tick();
      release dut.press;
      check("drop_state", 32'(state_o), 32'd3);
      check("drop_A", 32'(A), 32'h7);
      check("drop_Rq", 32'(R_q), 32'h2);
      tick();
      check("drop_after_state", 32'(state_o), 32'd3);
      check("drop_after_A", 32'(A), 32'h7);
      settle();

      // op_count wrap over 256 operations
      do_reset();
      for (int i = 0; i < 255; i++) begin
         press_act(4'(i));
         settle();
         press_act(4'(i + 3));
         tick();
         settle();
      end
      check("wrap_255", 32'(op_count), 32'd255);
      press_act(4'h1);
      settle();
      press_act(4'h1);
      tick();
      check("wrap_0", 32'(op_count), 32'd0);
      check("wrap_valid", 32'(valid), 32'd1);
      settle();

      // reset in GOT_A
      do_reset();
      press_act(4'h9);
      check("mid_A", 32'(A), 32'h9);
      check("mid_state_pre", 32'(state_o), 32'd1);
      settle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_state", 32'(state_o), 32'd0);
      check("mid_A_clr", 32'(A), 32'h0);
      check("mid_valid", 32'(valid), 32'd0);
      settle();
      press_act(4'h4);
      check("mid_next_is_A", 32'(A), 32'h4);
      check("mid_next_B", 32'(B), 32'h0);
      check("mid_next_state", 32'(state_o), 32'd1);
      settle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
